branch_predictor: RTL
=====================

# branch_predictor

- Parametrised branch target buffer (BTB) with per-entry saturating direction counters for the pipelined datapath.
- The IF stage looks up the current PC in the same cycle and receives a predicted next PC.
- The resolving stage (EX/MEM) writes back the actual outcome, counter updates, allocations and misprediction statistics.
- Replaces the fixed "predict not-taken, flush on taken" policy with a trained, clearable predictor.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- CTR_BITS, 2, width of each direction counter; minimum 1.
- WORD_W, 32, address/data width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- pc_IF  in  WORD_W  PC being fetched.
- pred_hit  out  1  valid entry with matching tag for pc_IF.
- pred_taken  out  1  pred_hit and counter MSB set.
- pred_target  out  WORD_W  stored target when pred_taken, else pc_IF+4.
- upd_valid  in  1  a branch resolved this cycle; caller qualifies with stall/flush.
- upd_pc  in  WORD_W  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  WORD_W  actual taken target.
- upd_pred_taken  in  1  prediction carried down the pipe with the branch.
- upd_pred_target  in  WORD_W  predicted next PC carried down the pipe.
- clear  in  1  invalidate all entries.
- mispredict  out  1  combinational; the pipe must redirect and flush this cycle.
- stat_branches  out  32  count of accepted updates.
- stat_mispredicts  out  32  count of mispredictions.

## Operation
Address split:
- IDX_W = log2(ENTRIES).
- index = pc[IDX_W+1:2]; tag = pc[WORD_W-1:IDX_W+2]; pc[1:0] ignored.
- Entry = {valid, tag, target, ctr}.

Lookup:
- Purely combinational from the table registers.
- pred_target = pc_IF + 4 on a miss or on a not-taken prediction.

Mispredict:
- mispredict = upd_valid and (upd_taken != upd_pred_taken or (upd_taken and upd_target != upd_pred_target)).
- Not-taken next PC is upd_pc+4 and is not compared.

Update, applied on the clock edge when upd_valid:
- Hit, taken: ctr saturating-increments (stops at all-ones); target <= upd_target.
- Hit, not-taken: ctr saturating-decrements (stops at 0); target unchanged.
- Miss, taken: allocate at index, overwriting any occupant; valid=1, tag, target; ctr = weakly taken (MSB=1, rest 0).
- Miss, not-taken: no table change.
- stat_branches += 1; stat_mispredicts += mispredict. Both wrap modulo 2^32.

Clear:
- All valid bits <= 0 next edge; counters, targets and stats are untouched.
- clear and upd_valid in the same cycle: clear wins for the table; stats still count the update.

Reset:
- All valid bits 0, all ctr 0, all targets 0, both stats 0.
- Therefore pred_hit=0, pred_taken=0, pred_target=pc_IF+4, mispredict follows its inputs.
- Reset overrides clear and update.

## Timing
- Lookup latency 0 cycles: pc_IF to pred_* combinational.
- Update visible to lookup on the cycle after the edge that writes it.
- No read bypass: a lookup and an update to the same index in the same cycle sees the old entry.
- Stats change one edge after the qualifying cycle.
- Critical path: tag compare plus mux to pred_target; the table is flops, not inferred RAM.

## Structure
- Shared package (bp_pkg, imported alongside cpu_types_pkg):
  - bp_entry_t struct, parametrised through the module by width localparams.
  - CTR_WEAK_TAKEN helper constant definition.
  - bp_outcome_t enum {BP_HIT_T, BP_HIT_NT, BP_MISS_T, BP_MISS_NT}.
- One sub-module: bp_sat_counter (CTR_BITS-parametrised combinational inc/dec with saturation), instantiated once on the update path.
- Table, stats and reset logic live in branch_predictor.

## Test plan
- Reset, then lookup pc_IF=0x40 -> pred_hit=0, pred_target=0x44, stats 0.
- Update pc=0x40 taken, target=0x100, pred_taken=0 -> mispredict=1. Next cycle: lookup 0x40 gives hit, taken, 0x100; stat_branches=1, stat_mispredicts=1.
- Four not-taken updates on 0x40 (CTR_BITS=2) -> ctr 10→01→00→00, pred_taken=0 after the first. Then two taken updates -> pred_taken=1 again.
- Aliasing, ENTRIES=16: allocate 0x40, then taken update on 0x80 (same index, different tag) -> lookup 0x40 misses, 0x80 hits.
- clear asserted together with a taken update to 0x200 -> no entries valid next cycle; stat_branches still increments.
- Same-cycle lookup and update of 0x40 -> old prediction on that cycle, new prediction the following cycle. stat_mispredicts preset near 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch target buffer.
package bp_pkg;

  // Default configuration widths; the predictor module derives its own
  // entry layout from its parameters using the same field order.
  localparam int unsigned BP_WORD_W   = 32;
  localparam int unsigned BP_ENTRIES  = 16;
  localparam int unsigned BP_CTR_BITS = 2;
  localparam int unsigned BP_IDX_W    = $clog2(BP_ENTRIES);
  localparam int unsigned BP_TAG_W    = BP_WORD_W - BP_IDX_W - 2;

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_WORD_W-1:0] target;
    logic [BP_CTR_BITS-1:0] ctr;
  } bp_entry_t;

  // Classification of a resolved branch against the table.
  typedef enum logic [1:0] {
    BP_HIT_T,
    BP_HIT_NT,
    BP_MISS_T,
    BP_MISS_NT
  } bp_outcome_t;

  // Weakly-taken counter value: MSB set, all lower bits clear.
  function automatic logic [31:0] ctr_weak_taken(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  localparam logic [31:0] CTR_WEAK_TAKEN = ctr_weak_taken(BP_CTR_BITS);

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup / update / statistics bundle between the pipeline and the predictor.
interface branch_predictor_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] pc_IF;
  logic              pred_hit;
  logic              pred_taken;
  logic [WORD_W-1:0] pred_target;
  logic              upd_valid;
  logic [WORD_W-1:0] upd_pc;
  logic              upd_taken;
  logic [WORD_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [WORD_W-1:0] upd_pred_target;
  logic              clear;
  logic              mispredict;
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispredicts;

  // Pipeline side.
  modport master (
    output pc_IF, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, clear,
    input  pred_hit, pred_taken, pred_target, mispredict,
           stat_branches, stat_mispredicts
  );

  // Predictor side.
  modport slave (
    input  pc_IF, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, clear,
    output pred_hit, pred_taken, pred_target, mispredict,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down direction counter (combinational next-value).
module bp_sat_counter #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_in,
  input  logic                inc,
  output logic [CTR_BITS-1:0] ctr_out
);

  // Increment toward all-ones on taken, decrement toward zero otherwise.
  always_comb begin
    ctr_out = ctr_in;
    if (inc) begin
      if (ctr_in != '1) ctr_out = ctr_in + 1'b1;
    end else begin
      if (ctr_in != '0) ctr_out = ctr_in - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters and branch statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned WORD_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  branch_predictor_if.slave bp
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = WORD_W - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_WT = CTR_BITS'(ctr_weak_taken(CTR_BITS));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  entry_t tbl_q [ENTRIES];

  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  logic [IDX_W-1:0]    lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  entry_t              lk_e, up_e;
  logic                lk_hit, up_hit;
  logic [CTR_BITS-1:0] ctr_next;
  bp_outcome_t         outcome;

  assign lk_idx = bp.pc_IF[IDX_W+1:2];
  assign lk_tag = bp.pc_IF[WORD_W-1:IDX_W+2];
  assign up_idx = bp.upd_pc[IDX_W+1:2];
  assign up_tag = bp.upd_pc[WORD_W-1:IDX_W+2];

  // Same-cycle lookup straight from the table flops (no update bypass).
  always_comb begin
    lk_e           = tbl_q[lk_idx];
    lk_hit         = lk_e.valid && (lk_e.tag == lk_tag);
    bp.pred_hit    = lk_hit;
    bp.pred_taken  = lk_hit && lk_e.ctr[CTR_BITS-1];
    bp.pred_target = (lk_hit && lk_e.ctr[CTR_BITS-1]) ? lk_e.target
                                                      : bp.pc_IF + WORD_W'(4);
  end

  // Redirect when direction differs, or taken to a different target.
  always_comb begin
    bp.mispredict = bp.upd_valid &&
                    ((bp.upd_taken != bp.upd_pred_taken) ||
                     (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
  end

  // Classify the resolving branch against its table slot.
  always_comb begin
    up_e   = tbl_q[up_idx];
    up_hit = up_e.valid && (up_e.tag == up_tag);
    if (up_hit) outcome = bp.upd_taken ? BP_HIT_T  : BP_HIT_NT;
    else        outcome = bp.upd_taken ? BP_MISS_T : BP_MISS_NT;
  end

  bp_sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .ctr_in  (up_e.ctr),
    .inc     (bp.upd_taken),
    .ctr_out (ctr_next)
  );

  // Table training/allocation, clear, and statistics counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (bp.upd_valid) begin
        stat_branches_q    <= stat_branches_q + 32'd1;
        stat_mispredicts_q <= stat_mispredicts_q + 32'(bp.mispredict);
      end
      // Clear takes priority over training; only valid bits are dropped.
      if (bp.clear) begin
        for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
      end else if (bp.upd_valid) begin
        case (outcome)
          BP_HIT_T: begin
            tbl_q[up_idx].ctr    <= ctr_next;
            tbl_q[up_idx].target <= bp.upd_target;
          end
          BP_HIT_NT: tbl_q[up_idx].ctr <= ctr_next;
          BP_MISS_T: begin
            tbl_q[up_idx].valid  <= 1'b1;
            tbl_q[up_idx].tag    <= up_tag;
            tbl_q[up_idx].target <= bp.upd_target;
            tbl_q[up_idx].ctr    <= CTR_WT;
          end
          default: ;
        endcase
      end
    end
  end

  assign bp.stat_branches    = stat_branches_q;
  assign bp.stat_mispredicts = stat_mispredicts_q;

endmodule
